// File: rtl/stopwatch_io.sv
// stopwatch_io: tick dividers, button debouncers and a multiplexed MM:SS 7-segment driver.
module stopwatch_io #(
    parameter int DIV_1HZ   = 100_000_000,
    parameter int DIV_2HZ   = 50_000_000,
    parameter int DIV_5HZ   = 20_000_000,
    parameter int SCAN_BITS = 18,
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_reset_raw,
    input  logic        btn_pause_raw,
    input  logic [12:0] seconds,
    input  logic        adj,
    input  logic [1:0]  sel,
    output logic        tick_1hz,
    output logic        tick_2hz,
    output logic        tick_5hz,
    output logic        btn_reset,
    output logic        btn_pause,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an
);
    localparam int DBW = $clog2(DB_CYCLES + 1);

    logic [26:0]          c1;
    logic [25:0]          c2, c5;
    logic                 blink;
    logic [SCAN_BITS-1:0] scan;
    logic [1:0]           raw, db;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c1       <= '0;
            c2       <= '0;
            c5       <= '0;
            tick_1hz <= 1'b0;
            tick_2hz <= 1'b0;
            tick_5hz <= 1'b0;
            blink    <= 1'b0;
            scan     <= '0;
        end else begin
            c1       <= (c1 == 27'(DIV_1HZ - 1)) ? '0 : c1 + 27'd1;
            c2       <= (c2 == 26'(DIV_2HZ - 1)) ? '0 : c2 + 26'd1;
            c5       <= (c5 == 26'(DIV_5HZ - 1)) ? '0 : c5 + 26'd1;
            tick_1hz <= c1 == 27'(DIV_1HZ - 1);
            tick_2hz <= c2 == 26'(DIV_2HZ - 1);
            tick_5hz <= c5 == 26'(DIV_5HZ - 1);
            blink    <= blink ^ tick_2hz;
            scan     <= scan + SCAN_BITS'(1);
        end
    end

    assign raw = {btn_pause_raw, btn_reset_raw};

    for (genvar b = 0; b < 2; b++) begin : g_db
        logic           s1, s2, q;
        logic [DBW-1:0] cnt;
        // The count only advances while the synchronized input disagrees with the accepted level
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                s1  <= 1'b0;
                s2  <= 1'b0;
                q   <= 1'b0;
                cnt <= '0;
            end else begin
                s1 <= raw[b];
                s2 <= s1;
                if (s2 != q) begin
                    if (cnt == DBW'(DB_CYCLES - 1)) begin
                        q   <= s2;
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + DBW'(1);
                    end
                end else begin
                    cnt <= '0;
                end
            end
        end
        assign db[b] = q;
    end

    assign btn_reset = db[0];
    assign btn_pause = db[1];

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'b1000000;
            4'd1:    seg_code = 7'b1111001;
            4'd2:    seg_code = 7'b0100100;
            4'd3:    seg_code = 7'b0110000;
            4'd4:    seg_code = 7'b0011001;
            4'd5:    seg_code = 7'b0010010;
            4'd6:    seg_code = 7'b0000010;
            4'd7:    seg_code = 7'b1111000;
            4'd8:    seg_code = 7'b0000000;
            4'd9:    seg_code = 7'b0010000;
            default: seg_code = 7'h7F;
        endcase
    endfunction

    logic [1:0] idx;
    logic       sat, blank;
    logic [6:0] m;
    logic [5:0] s;
    logic [3:0] dig;

    assign idx = scan[SCAN_BITS-1 -: 2];

    // Counts of 100 minutes or more pin the display at 99:59
    always_comb begin
        sat   = seconds >= 13'd6000;
        m     = sat ? 7'd99 : 7'(seconds / 13'd60);
        s     = sat ? 6'd59 : 6'(seconds % 13'd60);
        dig   = idx == 2'd3 ? 4'(m / 7'd10) :
                idx == 2'd2 ? 4'(m % 7'd10) :
                idx == 2'd1 ? 4'(s / 6'd10) : 4'(s % 6'd10);
        blank = adj && blink && (idx == sel);
        seg   = blank ? 7'h7F : seg_code(dig);
        dp    = blank || (idx != 2'd2);
        an    = ~(4'b0001 << idx);
    end
endmodule

// File: tb/tb_stopwatch_io.sv
// tb_stopwatch_io: randomized and directed checks of stopwatch_io against an arithmetic reference model.
module tb_stopwatch_io;
    logic        clk = 1'b0, rst = 1'b1;
    logic        btn_reset_raw = 1'b0, btn_pause_raw = 1'b0;
    logic [12:0] seconds = 13'd0;
    logic        adj = 1'b0;
    logic [1:0]  sel = 2'd0;
    logic        tick_1hz, tick_2hz, tick_5hz, btn_reset, btn_pause, dp;
    logic [6:0]  seg;
    logic [3:0]  an;

    int n = 0, checks = 0, errors = 0, exp_br = 0, exp_bp = 0;

    logic [6:0] code [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    logic [3:0] an_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    int bounds [6] = '{0, 754, 5999, 6000, 6039, 8191};

    stopwatch_io #(.DIV_1HZ(10), .DIV_2HZ(5), .DIV_5HZ(2), .SCAN_BITS(4), .DB_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .btn_reset_raw(btn_reset_raw), .btn_pause_raw(btn_pause_raw),
        .seconds(seconds), .adj(adj), .sel(sel), .tick_1hz(tick_1hz), .tick_2hz(tick_2hz),
        .tick_5hz(tick_5hz), .btn_reset(btn_reset), .btn_pause(btn_pause), .seg(seg), .dp(dp), .an(an)
    );

    always #5 clk = ~clk;

    // Rising edges since the last reset release
    always @(posedge clk or negedge rst)
        if (!rst) n <= 0;
        else n <= n + 1;

    function automatic int scan_idx(int c);
        return (c % 16) / 4;
    endfunction

    function automatic bit blanked(int c, bit a, int sl);
        bit ph = (c >= 1) ? bit'(((c - 1) / 5) % 2) : 1'b0;
        return a && ph && (scan_idx(c) == sl);
    endfunction

    function automatic logic [6:0] exp_seg(int sec, bit a, int sl, int c);
        int mm, ss, d;
        mm = sec / 60;
        ss = sec % 60;
        if (sec >= 6000) begin mm = 99; ss = 59; end
        case (scan_idx(c))
            3: d = mm / 10;
            2: d = mm % 10;
            1: d = ss / 10;
            default: d = ss % 10;
        endcase
        return blanked(c, a, sl) ? 7'h7F : code[d];
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("tick_1hz", 32'(tick_1hz), 32'(n > 0 && n % 10 == 0));
        chk("tick_2hz", 32'(tick_2hz), 32'(n > 0 && n % 5 == 0));
        chk("tick_5hz", 32'(tick_5hz), 32'(n > 0 && n % 2 == 0));
        chk("an", 32'(an), 32'(an_tab[scan_idx(n)]));
        chk("seg", 32'(seg), 32'(exp_seg(int'(seconds), adj, int'(sel), n)));
        chk("dp", 32'(dp), 32'(!(scan_idx(n) == 2 && !blanked(n, adj, int'(sel)))));
        if (exp_br >= 0) chk("btn_reset", 32'(btn_reset), 32'(exp_br));
        if (exp_bp >= 0) chk("btn_pause", 32'(btn_pause), 32'(exp_bp));
    endtask

    task automatic step(int k);
        repeat (k) begin
            @(negedge clk);
            #1;
            check_all();
        end
    endtask

    // Clean edge on one raw button; accepted level must follow 10 +/- 1 edges later
    task automatic press(bit which, bit lvl);
        int old = int'(!lvl);
        if (which) btn_pause_raw = lvl; else btn_reset_raw = lvl;
        for (int k = 1; k <= 20; k++) begin
            if (which) exp_bp = (k <= 8) ? old : (k >= 12) ? int'(lvl) : -1;
            else exp_br = (k <= 8) ? old : (k >= 12) ? int'(lvl) : -1;
            step(1);
        end
    endtask

    task automatic glitch(bit which, int len);
        if (which) btn_pause_raw = 1'b1; else btn_reset_raw = 1'b1;
        step(len);
        if (which) btn_pause_raw = 1'b0; else btn_reset_raw = 1'b0;
        step(12);
    endtask

    initial begin
        #2 rst = 1'b0;
        #1 check_all();
        step(3);
        @(negedge clk);
        rst = 1'b1;
        seconds = 13'd754;
        step(34);
        seconds = 13'd6039;
        step(16);
        seconds = 13'd0;
        step(16);
        seconds = 13'd754;
        adj = 1'b1;
        sel = 2'd2;
        step(40);
        adj = 1'b0;
        step(20);
        for (int i = 0; i < 300; i++) begin
            seconds = ($urandom_range(0, 3) == 0) ? 13'(bounds[$urandom_range(0, 5)])
                                                  : 13'($urandom_range(0, 8191));
            adj = 1'($urandom_range(0, 1));
            sel = 2'($urandom_range(0, 3));
            step(1);
        end
        adj = 1'b0;
        glitch(1'b1, 5);
        for (int i = 0; i < 4; i++) glitch(1'b1, $urandom_range(1, 7));
        for (int i = 0; i < 3; i++) glitch(1'b0, $urandom_range(1, 7));
        press(1'b1, 1'b1);
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        press(1'b0, 1'b0);
        press(1'b1, 1'b1);
        press(1'b0, 1'b1);
        step(7);
        @(negedge clk);
        #2 rst = 1'b0;
        btn_pause_raw = 1'b0;
        btn_reset_raw = 1'b0;
        exp_bp = 0;
        exp_br = 0;
        #1 check_all();
        step(3);
        @(negedge clk);
        rst = 1'b1;
        seconds = 13'($urandom_range(0, 8191));
        step(25);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
